// File: rtl/led_serial_out.sv
// Serial output stage for the LED status word: one-deep pending buffer, MSB-first shifter, latch pulse.
// Optional auto re-send of the last frame after an idle period is enabled by defining LED_AUTO_REFRESH_EN.
module led_serial_out #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned REFRESH_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sclk,
  output logic             sdata,
  output logic             slatch,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] pend;
  logic             pend_full;
  logic [WIDTH-1:0] shift_reg;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             phase;

  logic             accept;
  logic             div_end;
  logic             load_pending;
  logic             shift_en;
  logic             frame_end;

`ifdef LED_AUTO_REFRESH_EN
  localparam int unsigned REF_W = $clog2(REFRESH_CYCLES + 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

  logic [WIDTH-1:0] shadow;
  logic [REF_W-1:0] refresh_cnt;
  logic             load_shadow;
`endif

  assign accept  = data_valid && !pend_full;
  assign div_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    load_pending = 1'b0;
    shift_en     = 1'b0;
    frame_end    = 1'b0;
`ifdef LED_AUTO_REFRESH_EN
    load_shadow  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pend_full) begin
          load_pending = 1'b1;
          state_next   = SHIFT;
        end
`ifdef LED_AUTO_REFRESH_EN
        else if (refresh_cnt == REF_LAST) begin
          load_shadow = 1'b1;
          state_next  = SHIFT;
        end
`endif
      end
      SHIFT: begin
        if (div_end && phase) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            state_next = LATCH;
          end
        end
      end
      LATCH: begin
        if (div_end) begin
          frame_end  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending buffer: accept and transfer are mutually exclusive since accept needs it empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend      <= '0;
      pend_full <= 1'b0;
    end else begin
      if (accept) begin
        pend      <= data_in;
        pend_full <= 1'b1;
      end else if (load_pending) begin
        pend_full <= 1'b0;
      end
    end
  end

  // Divider and sclk phase; the divider is reused to time the latch pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        div_cnt <= '0;
        phase   <= 1'b0;
      end else begin
        div_cnt <= div_end ? '0 : div_cnt + 1'b1;
        if (state == SHIFT && div_end) begin
          phase <= ~phase;
        end else if (state != SHIFT) begin
          phase <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      if (load_pending) begin
        shift_reg <= pend;
        bit_cnt   <= '0;
      end
`ifdef LED_AUTO_REFRESH_EN
      else if (load_shadow) begin
        shift_reg <= shadow;
        bit_cnt   <= '0;
      end
`endif
      else if (shift_en) begin
        shift_reg <= shift_reg << 1;
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

`ifdef LED_AUTO_REFRESH_EN
  // Counts only idle cycles with nothing pending; any frame start restarts the interval.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow      <= '0;
      refresh_cnt <= '0;
    end else begin
      if (load_pending) begin
        shadow <= pend;
      end
      if (load_pending || load_shadow) begin
        refresh_cnt <= '0;
      end else if (state == IDLE && !pend_full) begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
    end
  end

  assign data_ready = !pend_full;
  assign sclk       = (state == SHIFT) && phase;
  assign sdata      = (state == SHIFT) && shift_reg[WIDTH-1];
  assign slatch     = (state == LATCH);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_led_serial_out.sv
// Directed bench for led_serial_out: default, 8-bit/div-1 and 200-cycle-refresh instances.
module tb_led_serial_out;

  logic        clk;
  logic        reset;
  logic [15:0] din0, din2;
  logic [7:0]  din1;
  logic        dv0, dv1, dv2;
  logic        rdy0, rdy1, rdy2;
  logic        sclk0, sclk1, sclk2;
  logic        sd0, sd1, sd2;
  logic        sl0, sl1, sl2;
  logic        bsy0, bsy1, bsy2;
  logic        fd0, fd1, fd2;

  int checks;
  int failures;
  int sel;

  logic m_ready, m_sclk, m_sdata, m_slatch, m_busy, m_done;

  led_serial_out #(.WIDTH(16), .CLK_DIV(4), .REFRESH_CYCLES(65536)) dut (
    .clk(clk), .reset(reset), .data_in(din0), .data_valid(dv0), .data_ready(rdy0),
    .sclk(sclk0), .sdata(sd0), .slatch(sl0), .busy(bsy0), .frame_done(fd0));

  led_serial_out #(.WIDTH(8), .CLK_DIV(1), .REFRESH_CYCLES(65536)) dut8 (
    .clk(clk), .reset(reset), .data_in(din1), .data_valid(dv1), .data_ready(rdy1),
    .sclk(sclk1), .sdata(sd1), .slatch(sl1), .busy(bsy1), .frame_done(fd1));

  led_serial_out #(.WIDTH(16), .CLK_DIV(4), .REFRESH_CYCLES(200)) dutr (
    .clk(clk), .reset(reset), .data_in(din2), .data_valid(dv2), .data_ready(rdy2),
    .sclk(sclk2), .sdata(sd2), .slatch(sl2), .busy(bsy2), .frame_done(fd2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      1: begin
        m_ready = rdy1; m_sclk = sclk1; m_sdata = sd1; m_slatch = sl1; m_busy = bsy1; m_done = fd1;
      end
      2: begin
        m_ready = rdy2; m_sclk = sclk2; m_sdata = sd2; m_slatch = sl2; m_busy = bsy2; m_done = fd2;
      end
      default: begin
        m_ready = rdy0; m_sclk = sclk0; m_sdata = sd0; m_slatch = sl0; m_busy = bsy0; m_done = fd0;
      end
    endcase
  end

  typedef struct {
    int          lat;
    int          edges;
    int          l_first;
    int          l_cnt;
    int          done_k;
    int          b_cnt;
    int          sd_hi;
    int          tog;
    logic [31:0] bits;
  } res_t;

  typedef struct {
    int          sel;
    logic [15:0] word;
    logic [15:0] exp_bits;
    int          exp_edges;
    int          exp_l_first;
    int          exp_l_cnt;
    int          exp_done;
    int          exp_busy;
    int          exp_sd_hi;
    int          exp_tog;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Samples the current cycle first, then steps; k=0 is the first busy cycle.
  task automatic measure(input int max_cyc, output res_t r);
    int   k;
    bit   started;
    logic prev_sclk;
    r.lat = -1; r.edges = 0; r.l_first = -1; r.l_cnt = 0; r.done_k = -1;
    r.b_cnt = 0; r.sd_hi = 0; r.tog = 0; r.bits = '0;
    k = 0;
    started = 1'b0;
    prev_sclk = 1'b0;
    for (int n = 0; n < max_cyc && r.done_k < 0; n++) begin
      if (n > 0) step();
      if (!started && m_busy) begin
        started = 1'b1;
        r.lat = n;
        k = 0;
      end
      if (started) begin
        if (m_sclk && !prev_sclk) begin
          r.edges++;
          r.bits = {r.bits[30:0], m_sdata};
        end
        if (m_sclk != prev_sclk) r.tog++;
        if (m_slatch) begin
          if (r.l_first < 0) r.l_first = k;
          r.l_cnt++;
        end
        if (m_busy) r.b_cnt++;
        if (m_sdata) r.sd_hi++;
        if (m_done) r.done_k = k;
        k++;
      end
      prev_sclk = m_sclk;
    end
  endtask

  vec_t vecs[6];
  res_t r;
  int   cnt, cnt2, f;

  initial begin
    checks = 0;
    failures = 0;
    sel = 0;
    reset = 1'b0;
    din0 = '0; din1 = '0; din2 = '0;
    dv0 = 1'b0; dv1 = 1'b0; dv2 = 1'b0;

    vecs[0] = '{0, 16'hA5C3, 16'hA5C3, 16, 128, 4, 132, 132, 64, 32};
    vecs[1] = '{0, 16'h0000, 16'h0000, 16, 128, 4, 132, 132, 0, 32};
    vecs[2] = '{0, 16'hFFFF, 16'hFFFF, 16, 128, 4, 132, 132, 128, 32};
    vecs[3] = '{0, 16'h8001, 16'h8001, 16, 128, 4, 132, 132, 16, 32};
    vecs[4] = '{1, 16'h00FF, 16'h00FF, 8, 16, 1, 17, 17, 16, 16};
    vecs[5] = '{1, 16'h005A, 16'h005A, 8, 16, 1, 17, 17, 8, 16};

    repeat (3) step();
    chk("rst_sclk", int'(sclk0), 0);
    chk("rst_sdata", int'(sd0), 0);
    chk("rst_slatch", int'(sl0), 0);
    chk("rst_busy", int'(bsy0), 0);
    chk("rst_frame_done", int'(fd0), 0);
    chk("rst_data_ready", int'(rdy0), 1);
    reset = 1'b1;
    step();

    // Auto-refresh instance: 0x1234 then idle.
    sel = 2;
    din2 = 16'h1234; dv2 = 1'b1;
    step();
    dv2 = 1'b0;
    measure(400, r);
    chk("ref_f1_bits", int'(r.bits), 32'h1234);
    chk("ref_f1_done", r.done_k, 132);
`ifdef LED_AUTO_REFRESH_EN
    cnt = 0;
    while (!m_busy && cnt < 400) begin
      step();
      cnt++;
    end
    chk("ref_delay", cnt, 200);
    measure(400, r);
    chk("ref_f2_lat", r.lat, 0);
    chk("ref_f2_bits", int'(r.bits), 32'h1234);
    chk("ref_f2_done", r.done_k, 132);
`else
    cnt = 0;
    for (int n = 0; n < 10000; n++) begin
      step();
      if (m_busy) cnt++;
    end
    chk("ref_none", cnt, 0);
`endif

    for (int i = 0; i < 6; i++) begin
      sel = vecs[i].sel;
      if (sel == 1) begin din1 = vecs[i].word[7:0]; dv1 = 1'b1; end
      else begin din0 = vecs[i].word; dv0 = 1'b1; end
      step();
      chk($sformatf("v%0d_ready_low", i), int'(m_ready), 0);
      dv0 = 1'b0; dv1 = 1'b0;
      measure(400, r);
      chk($sformatf("v%0d_latency", i), r.lat, 1);
      chk($sformatf("v%0d_bits", i), int'(r.bits), int'(vecs[i].exp_bits));
      chk($sformatf("v%0d_edges", i), r.edges, vecs[i].exp_edges);
      chk($sformatf("v%0d_latch_first", i), r.l_first, vecs[i].exp_l_first);
      chk($sformatf("v%0d_latch_cnt", i), r.l_cnt, vecs[i].exp_l_cnt);
      chk($sformatf("v%0d_done", i), r.done_k, vecs[i].exp_done);
      chk($sformatf("v%0d_busy", i), r.b_cnt, vecs[i].exp_busy);
      chk($sformatf("v%0d_sdata_hi", i), r.sd_hi, vecs[i].exp_sd_hi);
      chk($sformatf("v%0d_toggles", i), r.tog, vecs[i].exp_tog);
      repeat (2) step();
    end

    // Back-to-back: 0x0001, then 0x8000 accepted mid-frame, third word held off.
    sel = 0;
    din0 = 16'h0001; dv0 = 1'b1;
    step();
    chk("b2b_ready_after_accept", int'(m_ready), 0);
    dv0 = 1'b0;
    step();
    chk("b2b_f1_busy", int'(m_busy), 1);
    chk("b2b_ready_reopen", int'(m_ready), 1);
    repeat (5) step();
    din0 = 16'h8000; dv0 = 1'b1;
    step();
    chk("b2b_ready_held", int'(m_ready), 0);
    din0 = 16'h3333;
    cnt = 0;
    f = -1;
    for (int n = 0; n < 300 && f < 0; n++) begin
      step();
      if (m_ready) cnt++;
      if (m_done) begin
        f = n;
        dv0 = 1'b0;
      end else begin
        din0 = 16'h3333 ^ 16'(n);
      end
    end
    chk("b2b_f1_done_seen", int'(f >= 0), 1);
    chk("b2b_ready_stayed_low", cnt, 0);
    step();
    chk("b2b_f2_ready", int'(m_ready), 1);
    measure(300, r);
    chk("b2b_f2_next_cycle", r.lat, 0);
    chk("b2b_f2_bits", int'(r.bits), 32'h8000);
    chk("b2b_f2_done", r.done_k, 132);
    cnt = 0;
    for (int n = 0; n < 200; n++) begin
      step();
      if (m_busy) cnt++;
    end
    chk("b2b_no_third", cnt, 0);

    // Valid held while data_in changes: only the accepting word goes out.
    din0 = 16'hC0DE; dv0 = 1'b1;
    step();
    din0 = 16'h1111;
    step();
    din0 = 16'h2222; dv0 = 1'b0;
    measure(300, r);
    chk("hold_lat", r.lat, 0);
    chk("hold_bits", int'(r.bits), 32'hC0DE);
    chk("hold_sdata_hi", r.sd_hi, 64);
    cnt = 0;
    for (int n = 0; n < 200; n++) begin
      step();
      if (m_busy) cnt++;
    end
    chk("hold_no_dup", cnt, 0);

    // Reset at frame cycle 50 with a word pending.
    din0 = 16'hFFFF; dv0 = 1'b1;
    step();
    dv0 = 1'b0;
    step();
    repeat (10) step();
    din0 = 16'h5555; dv0 = 1'b1;
    step();
    dv0 = 1'b0;
    repeat (39) step();
    chk("mid_pre_busy", int'(m_busy), 1);
    chk("mid_pre_sdata", int'(m_sdata), 1);
    chk("mid_pre_ready", int'(m_ready), 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_sclk", int'(m_sclk), 0);
    chk("mid_rst_sdata", int'(m_sdata), 0);
    chk("mid_rst_slatch", int'(m_slatch), 0);
    chk("mid_rst_busy", int'(m_busy), 0);
    chk("mid_rst_ready", int'(m_ready), 1);
    cnt = 0;
    cnt2 = 0;
    repeat (2) begin
      step();
      if (m_slatch) cnt2++;
    end
    reset = 1'b1;
    for (int n = 0; n < 300; n++) begin
      step();
      if (m_busy) cnt++;
      if (m_slatch) cnt2++;
    end
    chk("mid_no_frame", cnt, 0);
    chk("mid_no_latch", cnt2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
